obstacle_tracker: RTL and testbench

OBSTACLE_TRACKER -- requirements
Module: obstacle_tracker

---
 rtl/obstacle_tracker_pkg.sv | 21 ++
 rtl/obstacle_slot.sv | 47 ++++
 rtl/obstacle_tracker.sv | 186 ++++++++++++++++++
 tb/tb_obstacle_tracker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_tracker_pkg.sv
// ---------------------------------------------------------------------------
// obstacle_tracker_pkg
//   Shared definitions for the obstacle tracker:
//     scan_state_t   - scan FSM state encoding (IDLE / SCAN / DONE)
//     DEF_START_X    - default x of a freshly spawned obstacle (right edge)
//     DEF_SPEED      - default pixels scrolled per move tick
//     DEF_MAX_Y      - default largest legal obstacle y
// ---------------------------------------------------------------------------
package obstacle_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam logic [9:0] DEF_START_X = 10'd639;
  localparam logic [9:0] DEF_SPEED   = 10'd4;
  localparam logic [9:0] DEF_MAX_Y   = 10'd440;

endpackage

// File: rtl/obstacle_slot.sv
// ---------------------------------------------------------------------------
// obstacle_slot
//   One obstacle register: active flag plus x/y position.
//   Ports:
//     clk, reset       - clock, asynchronous active-high reset
//     load             - occupy the slot with load_x/load_y (wins over move)
//     load_x, load_y   - position written on load
//     move             - scroll left by SPEED; expires instead of wrapping
//     active, x, y     - current slot contents
// ---------------------------------------------------------------------------
module obstacle_slot
  import obstacle_tracker_pkg::*;
#(
  parameter logic [9:0] SPEED = DEF_SPEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [9:0] load_x,
  input  logic [9:0] load_y,
  input  logic       move,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else if (load) begin
      // Load is only issued to a free slot, so a simultaneous move never
      // touches the new obstacle: it starts exactly at load_x.
      active <= 1'b1;
      x      <= load_x;
      y      <= load_y;
    end else if (move && active) begin
      if (x >= SPEED) begin
        x <= x - SPEED;
      end else begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/obstacle_tracker.sv
// ---------------------------------------------------------------------------
// obstacle_tracker
//   Holds NUM_SLOTS scrolling obstacles and lets a drawer enumerate them.
//   Ports:
//     clk, reset            - clock, asynchronous active-high reset
//     spawn, spawn_y        - spawn request and its y
//     move_tick             - scroll strobe
//     scan_start, obj_ready - drawer scan request / handshake
//     obj_valid/obj_x/obj_y - currently scanned obstacle
//     scan_done             - one-cycle pulse ending a scan
//     drop                  - one-cycle pulse, a spawn was discarded
//     active_count          - number of occupied slots
//   Build option: OBSTACLE_YCLAMP_EN clamps spawn_y to MAX_Y.
//   While a scan runs, slot state is frozen; spawn/tick are held one-deep
//   and applied in the first IDLE cycle.
// ---------------------------------------------------------------------------
module obstacle_tracker
  import obstacle_tracker_pkg::*;
#(
  parameter int         NUM_SLOTS = 4,
  parameter logic [9:0] START_X   = DEF_START_X,
  parameter logic [9:0] SPEED     = DEF_SPEED,
  parameter logic [9:0] MAX_Y     = DEF_MAX_Y
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spawn,
  input  logic [9:0] spawn_y,
  input  logic       move_tick,
  input  logic       scan_start,
  input  logic       obj_ready,
  output logic       obj_valid,
  output logic [9:0] obj_x,
  output logic [9:0] obj_y,
  output logic       scan_done,
  output logic       drop,
  output logic [3:0] active_count
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  scan_state_t          state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 spawn_pend_reg, spawn_pend_next;
  logic                 tick_pend_reg, tick_pend_next;
  logic [9:0]           pend_y_reg, pend_y_next;
  logic                 drop_reg, drop_next;

  logic [NUM_SLOTS-1:0] slot_active;
  logic [9:0]           slot_x [NUM_SLOTS];
  logic [9:0]           slot_y [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] load_vec;

  logic       is_idle, do_spawn, do_tick, all_full, free_found;
  logic [9:0] spawn_y_src, load_y;

  assign is_idle     = (state_reg == IDLE);
  // A pending spawn is older than a same-cycle input, so it is served first.
  assign do_spawn    = is_idle && (spawn || spawn_pend_reg);
  assign do_tick     = is_idle && (move_tick || tick_pend_reg);
  assign spawn_y_src = spawn_pend_reg ? pend_y_reg : spawn_y;
  assign all_full    = &slot_active;

`ifdef OBSTACLE_YCLAMP_EN
  assign load_y = (spawn_y_src > MAX_Y) ? MAX_Y : spawn_y_src;
`else
  assign load_y = spawn_y_src;
`endif

  // Lowest-index free slot gets the load.
  always_comb begin
    load_vec   = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_active[i] && !free_found) begin
        load_vec[i] = do_spawn;
        free_found  = 1'b1;
      end
    end
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      active_count = active_count + 4'(slot_active[i]);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      obstacle_slot #(
        .SPEED (SPEED)
      ) u_slot (
        .clk    (clk),
        .reset  (reset),
        .load   (load_vec[gi]),
        .load_x (START_X),
        .load_y (load_y),
        .move   (do_tick),
        .active (slot_active[gi]),
        .x      (slot_x[gi]),
        .y      (slot_y[gi])
      );
    end
  endgenerate

  // Pending-event bookkeeping and drop generation.
  always_comb begin
    spawn_pend_next = spawn_pend_reg;
    tick_pend_next  = tick_pend_reg;
    pend_y_next     = pend_y_reg;
    drop_next       = 1'b0;
    if (is_idle) begin
      spawn_pend_next = 1'b0;
      tick_pend_next  = 1'b0;
      if (spawn_pend_reg && spawn) drop_next = 1'b1;
      if (do_spawn && all_full)    drop_next = 1'b1;
    end else begin
      if (spawn) begin
        if (spawn_pend_reg) begin
          drop_next = 1'b1;
        end else begin
          spawn_pend_next = 1'b1;
          pend_y_next     = spawn_y;
        end
      end
      if (move_tick) tick_pend_next = 1'b1;
    end
  end

  // Scan FSM next state and outputs.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    obj_valid  = 1'b0;
    scan_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (scan_start) begin
          state_next = SCAN;
          idx_next   = '0;
        end
      end
      SCAN: begin
        obj_valid = slot_active[idx_reg];
        if (!slot_active[idx_reg] || obj_ready) begin
          if (idx_reg == IDX_W'(NUM_SLOTS - 1)) begin
            state_next = DONE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      DONE: begin
        scan_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Slot contents cannot change during SCAN, so the muxed position is stable
  // for as long as obj_valid is held.
  assign obj_x = obj_valid ? slot_x[idx_reg] : '0;
  assign obj_y = obj_valid ? slot_y[idx_reg] : '0;
  assign drop  = drop_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      spawn_pend_reg <= 1'b0;
      tick_pend_reg  <= 1'b0;
      pend_y_reg     <= '0;
      drop_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      spawn_pend_reg <= spawn_pend_next;
      tick_pend_reg  <= tick_pend_next;
      pend_y_reg     <= pend_y_next;
      drop_reg       <= drop_next;
    end
  end

endmodule

// File: tb/tb_obstacle_tracker.sv
// ---------------------------------------------------------------------------
// tb_obstacle_tracker
//   Directed bench for obstacle_tracker (default parameters). Inputs change
//   1 time unit after a rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_obstacle_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       spawn;
  logic [9:0] spawn_y;
  logic       move_tick;
  logic       scan_start;
  logic       obj_ready;
  logic       obj_valid;
  logic [9:0] obj_x;
  logic [9:0] obj_y;
  logic       scan_done;
  logic       drop;
  logic [3:0] active_count;

  int vectors = 0;
  int miscompares = 0;

  obstacle_tracker dut (
    .clk          (clk),
    .reset        (reset),
    .spawn        (spawn),
    .spawn_y      (spawn_y),
    .move_tick    (move_tick),
    .scan_start   (scan_start),
    .obj_ready    (obj_ready),
    .obj_valid    (obj_valid),
    .obj_x        (obj_x),
    .obj_y        (obj_y),
    .scan_done    (scan_done),
    .drop         (drop),
    .active_count (active_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_spawn(input logic [9:0] y);
    spawn   = 1'b1;
    spawn_y = y;
    step();
    spawn   = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    move_tick = 1'b1;
    repeat (n) step();
    move_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    bit seen_done;
    reset = 1'b1; spawn = 1'b0; spawn_y = '0; move_tick = 1'b0;
    scan_start = 1'b0; obj_ready = 1'b0;
    step();
    check("rst_count", 32'(active_count), 0);
    check("rst_valid", 32'(obj_valid), 0);
    check("rst_done",  32'(scan_done), 0);
    check("rst_drop",  32'(drop), 0);
    check("rst_objx",  32'(obj_x), 0);
    reset = 1'b0;
    step();

    // First spawn lands in slot 0.
    do_spawn(10'd100);
    check("sp1_act",   32'(dut.g_slot[0].u_slot.active), 1);
    check("sp1_x",     32'(dut.g_slot[0].u_slot.x), 639);
    check("sp1_y",     32'(dut.g_slot[0].u_slot.y), 100);
    check("sp1_count", 32'(active_count), 1);

    // Fill remaining slots, fifth spawn is dropped.
    do_spawn(10'd200);
    do_spawn(10'd300);
    do_spawn(10'd400);
    check("sp4_count", 32'(active_count), 4);
    check("sp4_drop",  32'(drop), 0);
    check("sp4_y3",    32'(dut.g_slot[3].u_slot.y), 400);
    do_spawn(10'd50);
    check("sp5_drop",  32'(drop), 1);
    check("sp5_count", 32'(active_count), 4);
    check("sp5_y0",    32'(dut.g_slot[0].u_slot.y), 100);
    step();
    check("sp5_drop_end", 32'(drop), 0);

    // Expiry: 639 - 159*4 = 3 still active, the next tick frees it.
    do_reset();
    do_spawn(10'd100);
    do_ticks(159);
    check("tk159_x",   32'(dut.g_slot[0].u_slot.x), 3);
    check("tk159_act", 32'(dut.g_slot[0].u_slot.active), 1);
    do_ticks(1);
    check("tk160_act",   32'(dut.g_slot[0].u_slot.active), 0);
    check("tk160_count", 32'(active_count), 0);

    // Build slots 0 and 2 active with slot 1 freed.
    do_reset();
    do_spawn(10'd10);          // s0 x=639
    do_ticks(100);             // s0 x=239
    do_spawn(10'd20);          // s1 x=639
    do_ticks(60);              // s0 expires, s1 x=399
    do_spawn(10'd30);          // s0 x=639
    do_ticks(5);               // s0 619, s1 379
    do_spawn(10'd40);          // s2 x=639
    do_ticks(95);              // s1 expires, s0 239, s2 259
    check("pre_count", 32'(active_count), 2);
    check("pre_s1",    32'(dut.g_slot[1].u_slot.active), 0);

    // Scan with ready held low three cycles per object.
    scan_start = 1'b1; step(); scan_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("scan0_valid", 32'(obj_valid), 1);
      check("scan0_x",     32'(obj_x), 239);
      check("scan0_y",     32'(obj_y), 30);
      if (c < 2) step();
    end
    obj_ready = 1'b1; step(); obj_ready = 1'b0;
    check("scan1_valid", 32'(obj_valid), 0);
    step();
    for (int c = 0; c < 3; c++) begin
      check("scan2_valid", 32'(obj_valid), 1);
      check("scan2_x",     32'(obj_x), 259);
      check("scan2_y",     32'(obj_y), 40);
      if (c < 2) step();
    end
    obj_ready = 1'b1; step(); obj_ready = 1'b0;
    check("scan3_valid", 32'(obj_valid), 0);
    check("scan3_done",  32'(scan_done), 0);
    step();
    check("scan_done_pulse", 32'(scan_done), 1);
    step();
    check("scan_done_end", 32'(scan_done), 0);

    // Spawn + tick during a scan are deferred; second spawn is dropped.
    scan_start = 1'b1; step(); scan_start = 1'b0;
    spawn = 1'b1; spawn_y = 10'd77; move_tick = 1'b1;
    step();
    check("pend_s0_x", 32'(dut.g_slot[0].u_slot.x), 239);
    spawn_y = 10'd88;
    step();
    check("pend_drop", 32'(drop), 1);
    spawn = 1'b0; move_tick = 1'b0; obj_ready = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 12 && !seen_done; c++) begin
      step();
      if (scan_done) seen_done = 1'b1;
    end
    obj_ready = 1'b0;
    check("pend_scan_done", 32'(seen_done), 1);
    step();   // first IDLE cycle
    step();   // deferred events now applied
    check("pend_s0_x2",  32'(dut.g_slot[0].u_slot.x), 235);
    check("pend_s2_x",   32'(dut.g_slot[2].u_slot.x), 255);
    check("pend_s1_x",   32'(dut.g_slot[1].u_slot.x), 639);
    check("pend_s1_y",   32'(dut.g_slot[1].u_slot.y), 77);
    check("pend_count",  32'(active_count), 3);
    check("pend_drop0",  32'(drop), 0);

    // Asynchronous reset in the middle of a scan.
    scan_start = 1'b1; step(); scan_start = 1'b0;
    check("mid_valid", 32'(obj_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(obj_valid), 0);
    check("mid_rst_x",     32'(obj_x), 0);
    check("mid_rst_y",     32'(obj_y), 0);
    check("mid_rst_count", 32'(active_count), 0);
    step();
    reset = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (scan_done) seen_done = 1'b1;
    end
    check("mid_no_done", 32'(seen_done), 0);

    // Out-of-range y.
    do_spawn(10'd1000);
`ifdef OBSTACLE_YCLAMP_EN
    check("clamp_y", 32'(dut.g_slot[0].u_slot.y), 440);
`else
    check("clamp_y", 32'(dut.g_slot[0].u_slot.y), 1000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
